mkio_bc_control: RTL and testbench

- Bus-controller (BC) end of the MKIO channel; the initiator that drives the RT-side control logic.
- On a host start, it builds and sends a command word and then does one of two things:
  - BC->RT: sends N data words, then receives the RT status word.
  - RT->BC: receives the status word, then N data words into a local buffer.
- It uses the same word-level transmitter/receiver interface as the RT side and reports completion and error codes to the host.

---
 rtl/mkio_bc_control_pkg.sv | 45 ++++
 rtl/mkio_bc_control_if.sv | 17 +
 rtl/mkio_bc_control_buffer.sv | 38 +++
 rtl/mkio_bc_control.sv | 217 +++++++++++++++++++++
 tb/tb_mkio_bc_control.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mkio_bc_control_pkg.sv
// Shared types and constants for the MKIO bus-controller slice: FSM states,
// completion codes, sync types and the command/status word field layout.
package mkio_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TX_CMD,
    S_WAIT_TX,
    S_TX_RD,
    S_TX_DATA,
    S_RX_STATUS,
    S_RX_DATA,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_PARITY  = 3'd2;
  localparam logic [2:0] ERR_ADDR    = 3'd3;
  localparam logic [2:0] ERR_SYNC    = 3'd4;

  localparam logic SYNC_CMD  = 1'b0;
  localparam logic SYNC_DATA = 1'b1;

  localparam int RT_MSB    = 15;
  localparam int RT_LSB    = 11;
  localparam int WR_RD_BIT = 10;
  localparam int SA_MSB    = 9;
  localparam int SA_LSB    = 5;
  localparam int WC_MSB    = 4;
  localparam int WC_LSB    = 0;

  function automatic logic [15:0] build_cmd(logic [4:0] rt, logic wr, logic [4:0] sa,
                                            logic [4:0] wc);
    logic [15:0] w;
    w                = '0;
    w[RT_MSB:RT_LSB] = rt;
    w[WR_RD_BIT]     = wr;
    w[SA_MSB:SA_LSB] = sa;
    w[WC_MSB:WC_LSB] = wc;
    return w;
  endfunction

endpackage

// File: rtl/mkio_bc_control_if.sv
// Word-level transmitter/receiver link between the bus controller (master)
// and the MKIO line coder (slave).
interface mkio_bc_control_if;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_busy;
  logic        rx_done;
  logic [15:0] rx_data;
  logic        rx_cd;
  logic        p_error;

  modport master (output tx_ready, tx_data, tx_cd,
                  input  tx_busy, rx_done, rx_data, rx_cd, p_error);
  modport slave  (input  tx_ready, tx_data, tx_cd,
                  output tx_busy, rx_done, rx_data, rx_cd, p_error);
endinterface

// File: rtl/mkio_bc_control_buffer.sv
// Single-port 2^BUF_AW x 16 word buffer, 1-cycle read latency; the FSM owns
// the port while a transaction runs, otherwise the host does.
module mkio_bc_buffer #(
  parameter int BUF_AW = 5
) (
  input  logic              clk,
  input  logic              fsm_own,
  input  logic [BUF_AW-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  input  logic              host_we,
  input  logic [BUF_AW-1:0] fsm_addr,
  input  logic [15:0]       fsm_wdata,
  input  logic              fsm_we,
  output logic [15:0]       rdata
);

  logic [15:0]       mem [2**BUF_AW];
  logic [BUF_AW-1:0] addr;
  logic [15:0]       wdata;
  logic              we;
  logic [15:0]       rdata_d;
  logic [15:0]       rdata_q;

  always_comb begin
    addr    = fsm_own ? fsm_addr  : host_addr;
    wdata   = fsm_own ? fsm_wdata : host_wdata;
    we      = fsm_own ? fsm_we    : host_we;
    rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mkio_bc_control.sv
// MKIO bus-controller: sends a command word, then either transmits N data
// words and collects the RT status, or collects the status and N data words.
module mkio_bc_control
  import mkio_pkg::*;
#(
  parameter int RESP_TIMEOUT = 1000,
  parameter int BUF_AW       = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         rt_addr,
  input  logic [4:0]         subaddr,
  input  logic               wr_rd,
  input  logic [4:0]         word_cnt,
  output logic               busy,
  output logic               done,
  output logic [2:0]         err_code,
  output logic [15:0]        status_word,
  mkio_bc_control_if.master  bus,
  input  logic [BUF_AW-1:0]  buf_addr,
  input  logic [15:0]        buf_wdata,
  input  logic               buf_we,
  output logic [15:0]        buf_rdata
);

  localparam int TMO_W = $clog2(RESP_TIMEOUT + 1);

  state_t       state_q, state_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic [2:0]   err_q, err_d;
  logic [15:0]  status_q, status_d;
  logic         tx_ready_q, tx_ready_d, tx_cd_q, tx_cd_d;
  logic [15:0]  tx_data_q, tx_data_d;
  logic [4:0]   rt_q, rt_d, sa_q, sa_d;
  logic         wr_q, wr_d;
  logic [5:0]   cnt_q, cnt_d, idx_q, idx_d;
  logic         cmd_phase_q, cmd_phase_d, seen_busy_q, seen_busy_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [15:0]       ram_rdata;
  logic              fsm_we;
  logic [BUF_AW-1:0] fsm_addr;
  logic [15:0]       fsm_wdata;

  mkio_bc_buffer #(.BUF_AW(BUF_AW)) u_buffer (
    .clk        (clk),
    .fsm_own    (busy_q),
    .host_addr  (buf_addr),
    .host_wdata (buf_wdata),
    .host_we    (buf_we),
    .fsm_addr   (fsm_addr),
    .fsm_wdata  (fsm_wdata),
    .fsm_we     (fsm_we),
    .rdata      (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_OK;
      status_q    <= '0;
      tx_ready_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_cd_q     <= SYNC_CMD;
      rt_q        <= '0;
      sa_q        <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      cmd_phase_q <= 1'b0;
      seen_busy_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      status_q    <= status_d;
      tx_ready_q  <= tx_ready_d;
      tx_data_q   <= tx_data_d;
      tx_cd_q     <= tx_cd_d;
      rt_q        <= rt_d;
      sa_q        <= sa_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      cmd_phase_q <= cmd_phase_d;
      seen_busy_q <= seen_busy_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    status_d    = status_q;
    tx_ready_d  = 1'b0;
    tx_data_d   = tx_data_q;
    tx_cd_d     = tx_cd_q;
    rt_d        = rt_q;
    sa_d        = sa_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    cmd_phase_d = cmd_phase_q;
    seen_busy_d = seen_busy_q;
    tmo_d       = tmo_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_TX_CMD;
        busy_d  = 1'b1;
        err_d   = ERR_OK;
        rt_d    = rt_addr;
        sa_d    = subaddr;
        wr_d    = wr_rd;
        cnt_d   = (word_cnt == 5'd0) ? 6'd32 : {1'b0, word_cnt};
        idx_d   = '0;
      end
      S_TX_CMD: if (!bus.tx_busy) begin
        tx_ready_d  = 1'b1;
        tx_data_d   = build_cmd(rt_q, wr_q, sa_q, cnt_q[4:0]);
        tx_cd_d     = SYNC_CMD;
        cmd_phase_d = 1'b1;
        seen_busy_d = 1'b0;
        state_d     = S_WAIT_TX;
      end
      // Two-phase wait: the word is on the line only once tx_busy has risen and fallen.
      S_WAIT_TX: begin
        if (!seen_busy_q) begin
          if (bus.tx_busy) seen_busy_d = 1'b1;
        end else if (!bus.tx_busy) begin
          tmo_d       = '0;
          cmd_phase_d = 1'b0;
          if ((cmd_phase_q && wr_q) || (!cmd_phase_q && idx_q == cnt_q))
            state_d = S_RX_STATUS;
          else
            state_d = S_TX_RD;
        end
      end
      S_TX_RD: state_d = S_TX_DATA;
      S_TX_DATA: if (!bus.tx_busy) begin
        tx_ready_d  = 1'b1;
        tx_data_d   = ram_rdata;
        tx_cd_d     = SYNC_DATA;
        idx_d       = idx_q + 6'd1;
        seen_busy_d = 1'b0;
        state_d     = S_WAIT_TX;
      end
      S_RX_STATUS: begin
        if (bus.rx_done) begin
          if (bus.p_error) begin
            err_d = ERR_PARITY; state_d = S_ERROR;
          end else if (bus.rx_cd != SYNC_CMD) begin
            err_d = ERR_SYNC; state_d = S_ERROR;
          end else if (bus.rx_data[RT_MSB:RT_LSB] != rt_q) begin
            err_d = ERR_ADDR; state_d = S_ERROR;
          end else begin
            status_d = bus.rx_data;
            idx_d    = '0;
            tmo_d    = '0;
            state_d  = wr_q ? S_RX_DATA : S_DONE;
          end
        end else if (tmo_q == TMO_W'(RESP_TIMEOUT)) begin
          err_d = ERR_TIMEOUT; state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RX_DATA: begin
        if (bus.rx_done) begin
          if (bus.p_error) begin
            err_d = ERR_PARITY; state_d = S_ERROR;
          end else if (bus.rx_cd != SYNC_DATA) begin
            err_d = ERR_SYNC; state_d = S_ERROR;
          end else begin
            idx_d = idx_q + 6'd1;
            tmo_d = '0;
            if (idx_q + 6'd1 == cnt_q) state_d = S_DONE;
          end
        end else if (tmo_q == TMO_W'(RESP_TIMEOUT)) begin
          err_d = ERR_TIMEOUT; state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE, S_ERROR: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Faulty words are not stored; only clean data words reach the buffer.
  always_comb begin
    fsm_addr  = BUF_AW'(idx_q);
    fsm_wdata = bus.rx_data;
    fsm_we    = (state_q == S_RX_DATA) && bus.rx_done && !bus.p_error &&
                (bus.rx_cd == SYNC_DATA);
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err_code     = err_q;
  assign status_word  = status_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_cd    = tx_cd_q;
  assign buf_rdata    = ram_rdata;

endmodule

// File: tb/tb_mkio_bc_control.sv
// Self-checking bench for mkio_bc_control: table of whole transactions plus
// hand-written sequences for timeout, faults, long transfers and reset.
module tb_mkio_bc_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  rt_addr, subaddr, word_cnt;
  logic        wr_rd;
  logic        busy, done;
  logic [2:0]  err_code;
  logic [15:0] status_word;
  logic [4:0]  buf_addr;
  logic [15:0] buf_wdata, buf_rdata;
  logic        buf_we;

  int checks = 0;
  int errors = 0;

  logic [16:0] tx_q[$];
  int          tx_left = 0;

  mkio_bc_control_if bus();

  mkio_bc_control #(.RESP_TIMEOUT(1000), .BUF_AW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .rt_addr(rt_addr), .subaddr(subaddr),
    .wr_rd(wr_rd), .word_cnt(word_cnt), .busy(busy), .done(done), .err_code(err_code),
    .status_word(status_word), .bus(bus), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .buf_we(buf_we), .buf_rdata(buf_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rt;
    logic [4:0]  sa;
    logic        wr;
    logic [4:0]  wc;
    logic [15:0] stat;
    logic        stat_cd;
    logic        stat_pe;
    logic [15:0] exp_cmd;
    logic [2:0]  exp_err;
    logic [15:0] exp_st;
  } vec_t;

  vec_t vecs[7];

  // Transmitter model: logs every tx_ready word, then stays busy for 3 cycles.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        tx_left     = 0;
        bus.tx_busy = 1'b0;
      end else begin
        if (bus.tx_ready) begin
          tx_q.push_back({bus.tx_cd, bus.tx_data});
          tx_left = 3;
        end
        if (tx_left > 0) begin
          bus.tx_busy = 1'b1;
          tx_left--;
        end else begin
          bus.tx_busy = 1'b0;
        end
      end
    end
  end

  function automatic logic [15:0] tx_word(int i);
    if (i < 3) return 16'(16'h1111 * (i + 1));
    return 16'(16'h4000 + i);
  endfunction

  function automatic logic [15:0] rx_word(int i);
    if (i == 0) return 16'hAAAA;
    if (i == 1) return 16'h5555;
    return 16'(16'h6000 + i);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rt, input logic [4:0] sa, input logic wr,
                               input logic [4:0] wc);
    @(negedge clk);
    rt_addr = rt; subaddr = sa; wr_rd = wr; word_cnt = wc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic host_write(input int a, input logic [15:0] d);
    @(negedge clk);
    buf_addr = 5'(a); buf_wdata = d; buf_we = 1'b1;
    @(negedge clk);
    buf_we = 1'b0;
  endtask

  task automatic host_read(input int a, output logic [15:0] d);
    @(negedge clk);
    buf_addr = 5'(a);
    @(negedge clk);
    d = buf_rdata;
  endtask

  task automatic send_rx(input logic [15:0] d, input logic cd, input logic pe);
    repeat (4) @(negedge clk);
    bus.rx_data = d; bus.rx_cd = cd; bus.p_error = pe; bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0; bus.p_error = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int max_cycles);
    bit ok = 0;
    for (int c = 0; c < max_cycles; c++) begin
      @(posedge clk);
      if (tx_q.size() >= n && tx_left == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("[TB] FAIL wait_tx: got %0d words, expected %0d", tx_q.size(), n);
    end
  endtask

  task automatic wait_done(input int max_cycles);
    bit ok = 0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("[TB] FAIL wait_done: got no done pulse, expected one within %0d cycles",
               max_cycles);
    end
  endtask

  function automatic logic [31:0] tx_at(int i);
    if (i < tx_q.size()) return 32'(tx_q[i]);
    return 32'hDEAD_0000;
  endfunction

  task automatic run_row(input vec_t v, input int row);
    int n;
    logic [15:0] d;
    n = (v.wc == 5'd0) ? 32 : int'(v.wc);
    for (int i = 0; i < n; i++) host_write(i, tx_word(i));
    tx_q.delete();
    applyStimulus(v.rt, v.sa, v.wr, v.wc);
    checkOutput($sformatf("row%0d busy", row), 32'(busy), 32'd1);
    wait_tx(v.wr ? 1 : n + 1, 3000);
    checkOutput($sformatf("row%0d cmd", row), tx_at(0), {16'd0, 1'b0, v.exp_cmd});
    if (!v.wr)
      for (int i = 0; i < n; i++)
        checkOutput($sformatf("row%0d txdata%0d", row, i), tx_at(i + 1),
                    {16'd0, 1'b1, tx_word(i)});
    send_rx(v.stat, v.stat_cd, v.stat_pe);
    if (v.wr && v.exp_err == 3'd0)
      for (int i = 0; i < n; i++) send_rx(rx_word(i), 1'b1, 1'b0);
    wait_done(2000);
    checkOutput($sformatf("row%0d err", row), 32'(err_code), 32'(v.exp_err));
    checkOutput($sformatf("row%0d status", row), 32'(status_word), 32'(v.exp_st));
    checkOutput($sformatf("row%0d busy_end", row), 32'(busy), 32'd0);
    if (v.wr && v.exp_err == 3'd0)
      for (int i = 0; i < n; i++) begin
        host_read(i, d);
        checkOutput($sformatf("row%0d buf%0d", row, i), 32'(d), 32'(rx_word(i)));
      end
    if (v.exp_err == 3'd3) begin
      host_read(0, d);
      checkOutput($sformatf("row%0d buf0_kept", row), 32'(d), 32'(tx_word(0)));
    end
  endtask

  initial begin
    logic [15:0] d;
    int n;
    int hits;

    vecs[0] = '{5'd1,  5'd2,  1'b0, 5'd3, 16'h0800, 1'b0, 1'b0, 16'h0843, 3'd0, 16'h0800};
    vecs[1] = '{5'd1,  5'd4,  1'b1, 5'd2, 16'h0800, 1'b0, 1'b0, 16'h0C82, 3'd0, 16'h0800};
    vecs[2] = '{5'd31, 5'd0,  1'b0, 5'd1, 16'hF800, 1'b0, 1'b0, 16'hF801, 3'd0, 16'hF800};
    vecs[3] = '{5'd1,  5'd4,  1'b1, 5'd2, 16'h1000, 1'b0, 1'b0, 16'h0C82, 3'd3, 16'hF800};
    vecs[4] = '{5'd5,  5'd31, 1'b1, 5'd1, 16'h2800, 1'b0, 1'b0, 16'h2FE1, 3'd0, 16'h2800};
    vecs[5] = '{5'd1,  5'd2,  1'b0, 5'd1, 16'h0800, 1'b1, 1'b0, 16'h0841, 3'd4, 16'h2800};
    vecs[6] = '{5'd1,  5'd2,  1'b0, 5'd1, 16'h0800, 1'b0, 1'b1, 16'h0841, 3'd2, 16'h2800};

    reset = 1'b1; start = 1'b0; rt_addr = '0; subaddr = '0; wr_rd = 1'b0; word_cnt = '0;
    buf_addr = '0; buf_wdata = '0; buf_we = 1'b0;
    bus.rx_done = 1'b0; bus.rx_data = '0; bus.rx_cd = 1'b0; bus.p_error = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset err", 32'(err_code), 32'd0);
    checkOutput("reset status", 32'(status_word), 32'd0);
    checkOutput("reset tx_ready", 32'(bus.tx_ready), 32'd0);
    checkOutput("reset tx_data", 32'(bus.tx_data), 32'd0);
    checkOutput("reset tx_cd", 32'(bus.tx_cd), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      run_row(vecs[r], r);
      repeat (3) @(negedge clk);
    end

    // start while busy, and a host write while busy, must both be ignored
    $display("[TB] start while busy");
    host_write(0, tx_word(0));
    host_write(1, tx_word(1));
    tx_q.delete();
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd2);
    host_write(0, 16'hBEEF);
    applyStimulus(5'd7, 5'd9, 1'b1, 5'd5);
    wait_tx(3, 500);
    checkOutput("sb cmd", tx_at(0), 32'h0_0842);
    checkOutput("sb tx1", tx_at(1), 32'h1_1111);
    checkOutput("sb tx2", tx_at(2), 32'h1_2222);
    send_rx(16'h0800, 1'b0, 1'b0);
    wait_done(200);
    checkOutput("sb err", 32'(err_code), 32'd0);
    checkOutput("sb tx_count", 32'(tx_q.size()), 32'd3);
    host_read(0, d);
    checkOutput("sb buf0", 32'(d), 32'h1111);

    $display("[TB] word_cnt 0 transfers 32 words");
    for (int i = 0; i < 32; i++) host_write(i, tx_word(i));
    tx_q.delete();
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0);
    wait_tx(33, 3000);
    checkOutput("wc0 count", 32'(tx_q.size()), 32'd33);
    checkOutput("wc0 cmd", tx_at(0), 32'h0_0840);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("wc0 tx%0d", i), tx_at(i + 1), {16'd0, 1'b1, tx_word(i)});
    send_rx(16'h0800, 1'b0, 1'b0);
    wait_done(200);
    checkOutput("wc0 err", 32'(err_code), 32'd0);

    $display("[TB] parity on 2nd data word");
    host_write(0, 16'h1111);
    tx_q.delete();
    applyStimulus(5'd1, 5'd4, 1'b1, 5'd2);
    wait_tx(1, 500);
    send_rx(16'h0800, 1'b0, 1'b0);
    send_rx(16'hAAAA, 1'b1, 1'b0);
    send_rx(16'h5555, 1'b1, 1'b1);
    wait_done(200);
    checkOutput("par err", 32'(err_code), 32'd2);
    host_read(0, d);
    checkOutput("par buf0", 32'(d), 32'hAAAA);

    $display("[TB] data with command sync");
    tx_q.delete();
    applyStimulus(5'd1, 5'd4, 1'b1, 5'd2);
    wait_tx(1, 500);
    send_rx(16'h0800, 1'b0, 1'b0);
    send_rx(16'hAAAA, 1'b0, 1'b0);
    wait_done(200);
    checkOutput("sync err", 32'(err_code), 32'd4);

    $display("[TB] response timeout");
    tx_q.delete();
    applyStimulus(5'd1, 5'd4, 1'b1, 5'd2);
    wait_tx(1, 500);
    n = 1101;
    for (int c = 1; c <= 1100; c++) begin
      @(negedge clk);
      if (done) begin n = c; break; end
    end
    checks++;
    if (n < 995 || n > 1010) begin
      errors++;
      $display("[TB] FAIL timeout latency: got %0d cycles, expected 995..1010", n);
    end
    checkOutput("tmo err", 32'(err_code), 32'd1);
    checkOutput("tmo busy", 32'(busy), 32'd0);

    $display("[TB] reset during data transmission");
    for (int i = 0; i < 3; i++) host_write(i, tx_word(i));
    tx_q.delete();
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd3);
    wait_tx(2, 500);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst tx_ready", 32'(bus.tx_ready), 32'd0);
    checkOutput("rst status", 32'(status_word), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    hits = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.tx_ready || busy) hits++;
    end
    checkOutput("rst idle after", 32'(hits), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
